// File: rtl/clk_ratio_meter_pkg.sv
// rtl/clk_ratio_meter_pkg.sv - shared FSM encodings and defaults for the divided-clock ratio meter
package clk_ratio_meter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_SYNC_STAGES = 2;
  localparam int unsigned DEFAULT_TIMEOUT     = 255;

endpackage

// File: rtl/clk_ratio_meter_bit_sync.sv
// rtl/clk_ratio_meter_bit_sync.sv - single-bit CDC flop chain, async active-low reset to 0
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_ratio_meter.sv
// rtl/clk_ratio_meter.sv - measures period and high/low split of a divided clock in ref-clock cycles
module clk_ratio_meter
  import clk_ratio_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic       i_ref_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_div_clk,
  output logic [7:0] o_ratio,
  output logic [7:0] o_high_cnt,
  output logic [7:0] o_low_cnt,
  output logic       o_valid,
  output logic       o_locked,
  output logic       o_stuck
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic       s, s_d_q;
  logic [7:0] cnt_q, cnt_d, high_tmp_q, high_tmp_d;
  logic [7:0] ratio_q, ratio_d, high_q, high_d, low_q, low_d;
  logic       valid_q, valid_d, locked_q, locked_d, stuck_q, stuck_d;
  logic       prev_seen_q, prev_seen_d;
  logic       rise, fall, edge_det, timeout;
  logic [8:0] sum;
  logic [7:0] sum_sat;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (i_ref_clk),
    .rst_ni (i_rst_n),
    .d_i    (i_div_clk),
    .q_o    (s)
  );

  assign rise     = s & ~s_d_q;
  assign fall     = ~s & s_d_q;
  assign edge_det = rise | fall;
  // An edge in the same cycle as the timeout wins, so the period is still measured.
  assign timeout  = (state_q != IDLE) && (cnt_q == TIMEOUT_CNT) && !edge_det;
  assign sum      = {1'b0, high_tmp_q} + {1'b0, cnt_q};
  assign sum_sat  = sum[8] ? 8'hFF : sum[7:0];

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!i_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:      state_d = WAIT_RISE;
        WAIT_RISE: if (rise) state_d = MEAS_HIGH;
        MEAS_HIGH: if (fall) state_d = MEAS_LOW;  else if (timeout) state_d = WAIT_RISE;
        MEAS_LOW:  if (rise) state_d = MEAS_HIGH; else if (timeout) state_d = WAIT_RISE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    high_tmp_d  = high_tmp_q;
    ratio_d     = ratio_q;
    high_d      = high_q;
    low_d       = low_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    stuck_d     = stuck_q;
    prev_seen_d = prev_seen_q;
    if (!i_en || state_q == IDLE) begin
      cnt_d       = 8'd0;
      locked_d    = 1'b0;
      stuck_d     = 1'b0;
      prev_seen_d = 1'b0;
    end else begin
      if (edge_det)                 cnt_d = 8'd1;
      else if (cnt_q != TIMEOUT_CNT) cnt_d = cnt_q + 8'd1;
      if (rise) stuck_d = 1'b0;
      if (timeout) begin
        stuck_d     = 1'b1;
        locked_d    = 1'b0;
        ratio_d     = 8'd0;
        prev_seen_d = 1'b0;
      end else if (state_q == MEAS_HIGH && fall) begin
        high_tmp_d = cnt_q;
      end else if (state_q == MEAS_LOW && rise) begin
        low_d       = cnt_q;
        high_d      = high_tmp_q;
        ratio_d     = sum_sat;
        valid_d     = 1'b1;
        locked_d    = (sum_sat == ratio_q) && prev_seen_q;
        prev_seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_d_q       <= 1'b0;
      cnt_q       <= 8'd0;
      high_tmp_q  <= 8'd0;
      ratio_q     <= 8'd0;
      high_q      <= 8'd0;
      low_q       <= 8'd0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      stuck_q     <= 1'b0;
      prev_seen_q <= 1'b0;
    end else begin
      s_d_q       <= s;
      cnt_q       <= cnt_d;
      high_tmp_q  <= high_tmp_d;
      ratio_q     <= ratio_d;
      high_q      <= high_d;
      low_q       <= low_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      stuck_q     <= stuck_d;
      prev_seen_q <= prev_seen_d;
    end
  end

  assign o_ratio    = ratio_q;
  assign o_high_cnt = high_q;
  assign o_low_cnt  = low_q;
  assign o_valid    = valid_q;
  assign o_locked   = locked_q;
  assign o_stuck    = stuck_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// tb/tb_clk_ratio_meter.sv - scoreboard bench for clk_ratio_meter
module tb_clk_ratio_meter;

  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       div = 1'b0;
  logic [7:0] o_ratio, o_high_cnt, o_low_cnt;
  logic       o_valid, o_locked, o_stuck;

  clk_ratio_meter #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
    .i_ref_clk  (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_div_clk  (div),
    .o_ratio    (o_ratio),
    .o_high_cnt (o_high_cnt),
    .o_low_cnt  (o_low_cnt),
    .o_valid    (o_valid),
    .o_locked   (o_locked),
    .o_stuck    (o_stuck)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ratio;
    logic [7:0] high;
    logic [7:0] low;
    logic       locked;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         vec_cnt = 0;
  int         err_cnt = 0;
  bit         m_prev_seen = 1'b0;
  logic [7:0] m_prev_ratio = 8'd0;
  int         n;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Divided clock launched just after a ref edge; holds v for n ref cycles.
  task automatic hold(input logic v, input int cycles);
    div = v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int h, input int l);
    exp_t e;
    int   r;
    r = (h + l > 255) ? 255 : h + l;
    e.ratio  = 8'(r);
    e.high   = 8'(h);
    e.low    = 8'(l);
    e.locked = m_prev_seen && (e.ratio == m_prev_ratio);
    m_prev_ratio = e.ratio;
    m_prev_seen  = 1'b1;
    sb.push_back(e);
  endtask

  task automatic run(input int h, input int l, input int periods);
    repeat (periods) begin
      push_exp(h, l);
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ratio"},  32'(o_ratio),    0);
    check_val({tag, "_high"},   32'(o_high_cnt), 0);
    check_val({tag, "_low"},    32'(o_low_cnt),  0);
    check_val({tag, "_valid"},  32'(o_valid),    0);
    check_val({tag, "_locked"}, 32'(o_locked),   0);
    check_val({tag, "_stuck"},  32'(o_stuck),    0);
  endtask

  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (sb.size() == 0) begin
        check_val("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_val("ratio",  32'(o_ratio),    32'(mon_e.ratio));
        check_val("high",   32'(o_high_cnt), 32'(mon_e.high));
        check_val("low",    32'(o_low_cnt),  32'(mon_e.low));
        check_val("locked", 32'(o_locked),   32'(mon_e.locked));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b1;
    hold(1'b0, 5);

    run(2, 2, 4);
    run(2, 3, 3);
    run(1, 1, 4);
    run(2, 2, 3);
    run(4, 4, 3);
    run(2, 2, 2);

    // Last rise closes the final ratio-4 period, then the clock stops low.
    hold(1'b1, 2);
    div = 1'b0;
    n = 0;
    while (!o_stuck && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("stuck_delay", 32'(n), 32'(SYNC_STAGES + 1 + TIMEOUT));
    check_val("stuck_ratio",  32'(o_ratio),  0);
    check_val("stuck_locked", 32'(o_locked), 0);
    m_prev_seen = 1'b0;
    repeat (300 - n) @(posedge clk);
    #1;

    push_exp(3, 3);
    div = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("stuck_clear", 32'(o_stuck), 0);
    hold(1'b0, 3);
    run(3, 3, 2);

    // Reset asserted while the meter sits in MEAS_LOW.
    hold(1'b1, 2);
    hold(1'b0, 4);
    check_val("pre_reset_ratio", 32'(o_ratio), 6);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    check_val("sb_empty_at_reset", 32'(sb.size()), 0);
    sb.delete();
    m_prev_seen  = 1'b0;
    m_prev_ratio = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b0, 4);
    run(2, 2, 3);
    hold(1'b1, 2);
    hold(1'b0, 2);

    // Disable mid-measurement: no further strobes, results held.
    en = 1'b0;
    hold(1'b1, 2);
    hold(1'b0, 2);
    hold(1'b1, 2);
    hold(1'b0, 3);
    check_val("idle_ratio_held", 32'(o_ratio),    4);
    check_val("idle_high_held",  32'(o_high_cnt), 2);
    check_val("idle_low_held",   32'(o_low_cnt),  2);
    check_val("idle_locked",     32'(o_locked),   0);
    check_val("idle_stuck",      32'(o_stuck),    0);
    check_val("sb_drained",      32'(sb.size()),  0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
